gcd_host: RTL

Initiator side of the GCD engine request/response interface. Accepts operand pairs from upstream over a valid/ready handshake and drives them into a GCD engine over a req/ack handshake. Guards each request with a timeout, then returns the result plus the echoed operands and an error code over a downstream valid/ready handshake. Sits between the command source and the GCD datapath; one transaction in flight at a time.

---
 rtl/gcd_host.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gcd_host.sv
// Initiator side of the GCD engine req/ack interface: one operand pair in flight,
// request guarded by a timeout. Optional local resolution of trivial pairs: GCD_HOST_BYPASS_EN.
module gcd_host #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        eng_req,
    output logic [31:0] eng_a,
    output logic [31:0] eng_b,
    input  logic        eng_ack,
    input  logic [31:0] eng_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_gcd,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [1:0]  out_err,
    output logic [15:0] stat_done
);

    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 16;
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ZERO = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [DW-1:0] TMO_LAST = DW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] op_a, op_b;
    logic [DW-1:0] tmo_cnt;
    logic          accept, ack_hit, tmo_hit, done_hs;
    logic          local_hit;
    logic [DW-1:0] local_gcd;
    logic [1:0]    local_err;

    assign accept  = (state == IDLE) && in_valid;
    assign ack_hit = (state == ISSUE) && eng_ack;
    assign tmo_hit = (state == ISSUE) && (tmo_cnt == TMO_LAST);
    assign done_hs = (state == RESP) && out_ready;

    // Pairs that can be answered without the engine
    always_comb begin
        local_hit = 1'b0;
        local_gcd = '0;
        local_err = ERR_OK;
        if (in_a == '0 && in_b == '0) begin
            local_hit = 1'b1;
            local_err = ERR_ZERO;
        end
`ifdef GCD_HOST_BYPASS_EN
        else if (in_a == '0) begin
            local_hit = 1'b1;
            local_gcd = in_b;
        end else if (in_b == '0 || in_a == in_b) begin
            local_hit = 1'b1;
            local_gcd = in_a;
        end
`endif
    end

    // State register; async reset also drops eng_req immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = local_hit ? RESP : ISSUE;
            ISSUE:   if (ack_hit || tmo_hit) state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        eng_req   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            ISSUE:   eng_req   = 1'b1;
            RESP:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operands, result, timeout counter and completion count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            out_gcd   <= '0;
            out_err   <= ERR_OK;
            tmo_cnt   <= '0;
            stat_done <= '0;
        end else begin
            if (accept) begin
                op_a    <= in_a;
                op_b    <= in_b;
                tmo_cnt <= '0;
                if (local_hit) begin
                    out_gcd <= local_gcd;
                    out_err <= local_err;
                end
            end
            if (state == ISSUE) tmo_cnt <= tmo_cnt + DW'(1);
            if (ack_hit) begin
                out_gcd <= eng_result;
                out_err <= ERR_OK;
            end else if (tmo_hit) begin
                out_gcd <= '0;
                out_err <= ERR_TMO;
            end
            if (done_hs) stat_done <= stat_done + SW'(1);
        end
    end

    assign eng_a = op_a;
    assign eng_b = op_b;
    assign out_a = op_a;
    assign out_b = op_b;

endmodule
